// File: rtl/alu_issue_sched.sv
// Round-robin issue scheduler feeding one fixed-latency ALU exe unit.
// Two-stage pipeline (issue A, execute B) returns tags aligned with the result.
module alu_issue_sched #(
  parameter int NREQ     = 4,
  parameter int DATA_LEN = 32,
  parameter int OP_W     = 4,
  parameter int RRF_W    = 6,
  parameter int ROB_W    = 6
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*OP_W-1:0]     req_alu_op_i,
  input  logic [NREQ*DATA_LEN-1:0] req_src1_i,
  input  logic [NREQ*DATA_LEN-1:0] req_src2_i,
  input  logic [NREQ-1:0]          req_wrrf_i,
  input  logic [NREQ*RRF_W-1:0]    req_rrf_tag_i,
  input  logic [NREQ*ROB_W-1:0]    req_rob_tag_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [NREQ-1:0]          grant_o,
  output logic                     exe_issue_o,
  output logic [OP_W-1:0]          exe_alu_op_o,
  output logic [DATA_LEN-1:0]      exe_src1_o,
  output logic [DATA_LEN-1:0]      exe_src2_o,
  output logic                     exe_wrrf_o,
  output logic                     wb_valid_o,
  output logic [RRF_W-1:0]         wb_rrf_tag_o,
  output logic [ROB_W-1:0]         wb_rob_tag_o,
  output logic                     busy_o
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    nxt_ptr;
  logic                win_any;
  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     grant;
  int unsigned         k;

  logic                valid_a, valid_b;
  logic [OP_W-1:0]     op_a, op_b;
  logic [DATA_LEN-1:0] src1_a, src1_b, src2_a, src2_b;
  logic                wrrf_a, wrrf_b;
  logic [RRF_W-1:0]    rrf_a, rrf_b;
  logic [ROB_W-1:0]    rob_a, rob_b;

  // Scan from ptr upward with wrap; the first eligible requester wins.
  always_comb begin
    elig    = req_valid_i & {NREQ{~stall_i & ~flush_i & reset_i}};
    grant   = '0;
    win_any = 1'b0;
    win_idx = '0;
    nxt_ptr = ptr;
    k       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!win_any && elig[k]) begin
        win_any  = 1'b1;
        win_idx  = PTR_W'(k);
        grant[k] = 1'b1;
        nxt_ptr  = PTR_W'((k + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ptr     <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      op_a    <= '0;
      src1_a  <= '0;
      src2_a  <= '0;
      wrrf_a  <= 1'b0;
      rrf_a   <= '0;
      rob_a   <= '0;
      op_b    <= '0;
      src1_b  <= '0;
      src2_b  <= '0;
      wrrf_b  <= 1'b0;
      rrf_b   <= '0;
      rob_b   <= '0;
    end else begin
      valid_a <= win_any;
      if (win_any) begin
        ptr    <= nxt_ptr;
        op_a   <= req_alu_op_i[int'(win_idx)*OP_W +: OP_W];
        src1_a <= req_src1_i[int'(win_idx)*DATA_LEN +: DATA_LEN];
        src2_a <= req_src2_i[int'(win_idx)*DATA_LEN +: DATA_LEN];
        wrrf_a <= req_wrrf_i[win_idx];
        rrf_a  <= req_rrf_tag_i[int'(win_idx)*RRF_W +: RRF_W];
        rob_a  <= req_rob_tag_i[int'(win_idx)*ROB_W +: ROB_W];
      end
      valid_b <= valid_a & ~flush_i;
      op_b    <= op_a;
      src1_b  <= src1_a;
      src2_b  <= src2_a;
      wrrf_b  <= wrrf_a;
      rrf_b   <= rrf_a;
      rob_b   <= rob_a;
    end
  end

  assign grant_o      = grant;
  assign exe_issue_o  = valid_a & ~flush_i;
  assign exe_alu_op_o = op_b;
  assign exe_src1_o   = src1_b;
  assign exe_src2_o   = src2_b;
  assign exe_wrrf_o   = wrrf_b;
  assign wb_valid_o   = valid_b & ~flush_i;
  assign wb_rrf_tag_o = rrf_b;
  assign wb_rob_tag_o = rob_b;
  assign busy_o       = valid_a | valid_b;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Randomized bench for alu_issue_sched against a queue-of-in-flight-ops model.
module tb_alu_issue_sched;

  localparam int N  = 4;
  localparam int DL = 32;
  localparam int OW = 4;
  localparam int RW = 6;
  localparam int BW = 6;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N*OW-1:0] req_alu_op_i = '0;
  logic [N*DL-1:0] req_src1_i = '0, req_src2_i = '0;
  logic [N-1:0]    req_wrrf_i = '0;
  logic [N*RW-1:0] req_rrf_tag_i = '0;
  logic [N*BW-1:0] req_rob_tag_i = '0;
  logic            stall_i = 1'b0, flush_i = 1'b0;
  logic [N-1:0]    grant_o;
  logic            exe_issue_o, exe_wrrf_o, wb_valid_o, busy_o;
  logic [OW-1:0]   exe_alu_op_o;
  logic [DL-1:0]   exe_src1_o, exe_src2_o;
  logic [RW-1:0]   wb_rrf_tag_o;
  logic [BW-1:0]   wb_rob_tag_o;

  alu_issue_sched #(.NREQ(N), .DATA_LEN(DL), .OP_W(OW), .RRF_W(RW), .ROB_W(BW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_valid_i(req_valid_i),
    .req_alu_op_i(req_alu_op_i), .req_src1_i(req_src1_i), .req_src2_i(req_src2_i),
    .req_wrrf_i(req_wrrf_i), .req_rrf_tag_i(req_rrf_tag_i), .req_rob_tag_i(req_rob_tag_i),
    .stall_i(stall_i), .flush_i(flush_i), .grant_o(grant_o),
    .exe_issue_o(exe_issue_o), .exe_alu_op_o(exe_alu_op_o),
    .exe_src1_o(exe_src1_o), .exe_src2_o(exe_src2_o), .exe_wrrf_o(exe_wrrf_o),
    .wb_valid_o(wb_valid_o), .wb_rrf_tag_o(wb_rrf_tag_o), .wb_rob_tag_o(wb_rob_tag_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [OW-1:0] op;
    logic [DL-1:0] s1, s2;
    logic        w;
    logic [RW-1:0] rrf;
    logic [BW-1:0] rob;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0;
  int   ptr = 0;
  bit   chk_zero = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      req_alu_op_i[i*OW +: OW]  = OW'($urandom);
      req_src1_i[i*DL +: DL]    = $urandom;
      req_src2_i[i*DL +: DL]    = $urandom;
      req_wrrf_i[i]             = 1'($urandom);
      req_rrf_tag_i[i*RW +: RW] = RW'($urandom);
      req_rob_tag_i[i*BW +: BW] = BW'($urandom);
    end
  endtask

  // One cycle: drive in the low phase, check, advance the model, return just after the edge.
  task automatic step(input logic [N-1:0] v, input logic st, input logic fl,
                      input logic rs, input bit rnd);
    logic [N-1:0] eg;
    int   win;
    bit   has_a, has_b;
    ent_t eb;
    @(negedge clk_i);
    req_valid_i = v; stall_i = st; flush_i = fl; reset_i = rs;
    if (rnd) rand_data();
    #1;
    eg = '0; win = -1;
    if (rs && !st && !fl)
      for (int off = 0; off < N; off++)
        if (win < 0 && v[(ptr + off) % N]) win = (ptr + off) % N;
    if (win >= 0) eg[win] = 1'b1;
    chk("grant", 64'(grant_o), 64'(eg));
    has_a = 0; has_b = 0;
    foreach (q[i]) begin
      if (q[i].cyc == cyc - 1) has_a = 1;
      if (q[i].cyc == cyc - 2) begin has_b = 1; eb = q[i]; end
    end
    chk("exe_issue", 64'(exe_issue_o), 64'(has_a && !fl));
    chk("wb_valid", 64'(wb_valid_o), 64'(has_b && !fl));
    chk("busy", 64'(busy_o), 64'(q.size() != 0));
    if (has_b) begin
      chk("alu_op", 64'(exe_alu_op_o), 64'(eb.op));
      chk("src1", 64'(exe_src1_o), 64'(eb.s1));
      chk("src2", 64'(exe_src2_o), 64'(eb.s2));
      chk("wrrf", 64'(exe_wrrf_o), 64'(eb.w));
      chk("rrf_tag", 64'(wb_rrf_tag_o), 64'(eb.rrf));
      chk("rob_tag", 64'(wb_rob_tag_o), 64'(eb.rob));
    end
    if (chk_zero) begin
      chk("zero_data", {exe_alu_op_o, exe_src1_o, exe_src2_o} | 64'(exe_wrrf_o), 64'd0);
      chk("zero_tags", 64'({wb_rrf_tag_o, wb_rob_tag_o}), 64'd0);
    end
    if (!rs || fl) q.delete();
    while (q.size() > 0 && q[0].cyc < cyc - 1) void'(q.pop_front());
    if (win >= 0) begin
      ent_t e;
      e.cyc = cyc;
      e.op  = req_alu_op_i[win*OW +: OW];
      e.s1  = req_src1_i[win*DL +: DL];
      e.s2  = req_src2_i[win*DL +: DL];
      e.w   = req_wrrf_i[win];
      e.rrf = req_rrf_tag_i[win*RW +: RW];
      e.rob = req_rob_tag_i[win*BW +: BW];
      q.push_back(e);
      ptr = (win + 1) % N;
    end
    if (!rs) ptr = 0;
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  initial begin
    step('0, 0, 0, 0, 1);
    chk_zero = 1;
    step('0, 0, 0, 0, 1);
    step('0, 0, 0, 1, 1);
    chk_zero = 0;

    // Single op from requester 0 with known operands and tags.
    req_alu_op_i = '0; req_src1_i = '0; req_src2_i = '0;
    req_src1_i[DL-1:0] = 32'd5; req_src2_i[DL-1:0] = 32'd7;
    req_wrrf_i = 4'b0001; req_rrf_tag_i[RW-1:0] = 6'd3; req_rob_tag_i[BW-1:0] = 6'd9;
    step(4'b0001, 0, 0, 1, 0);
    step(4'b0000, 0, 0, 1, 0);
    step(4'b0000, 0, 0, 1, 0);
    step(4'b0000, 0, 0, 1, 0);

    // All requesting from reset: full rotation, no bubbles.
    step(4'b1111, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(4'b1111, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(4'b0000, 0, 0, 1, 1);

    // Pointer skip: grant 1, then 1010 yields 3 then 1.
    step(4'b0000, 0, 0, 0, 1);
    step(4'b0010, 0, 0, 1, 1);
    step(4'b1010, 0, 0, 1, 1);
    step(4'b1010, 0, 0, 1, 1);

    // Single-cycle stall amid continuous requests.
    for (int i = 0; i < 3; i++) step(4'b1111, 0, 0, 1, 1);
    step(4'b1111, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(4'b1111, 0, 0, 1, 1);

    // Flush with two ops in flight.
    step(4'b1111, 0, 0, 1, 1);
    step(4'b1111, 0, 0, 1, 1);
    step(4'b1111, 1, 1, 1, 1);
    step(4'b0000, 0, 0, 1, 1);

    // Reset with both stages full, then lowest index wins.
    step(4'b1111, 0, 0, 1, 1);
    step(4'b1111, 0, 0, 1, 1);
    step(4'b1111, 0, 0, 0, 1);
    chk_zero = 1;
    step(4'b0110, 0, 0, 1, 1);
    chk_zero = 0;

    for (int i = 0; i < 2000; i++)
      step(N'($urandom), ($urandom_range(7) == 0), ($urandom_range(15) == 0),
           ($urandom_range(49) != 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_sched.md
# alu_issue_sched

Issue scheduler for one `AluExeUnit`. It arbitrates among `NREQ` ALU reservation-station requesters using round-robin and registers the winner's opcode and operands. It sequences the exe unit's `issue_i` and operand inputs so the operands stay stable during the exe unit's busy/result cycle, and it returns the RRF/ROB tags aligned with the exe unit's `rob_we_o`/`rrf_we_o`. Sustains one issue per cycle.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, ≥2.
- `DATA_LEN`, 32: operand width; equals `` `DATA_LEN``.
- `OP_W`, `` `ALU_OP_WIDTH``: ALU opcode width.
- `RRF_W`, 6: rename-register tag width.
- `ROB_W`, 6: ROB tag width.

Ports:
- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `reset_i` in 1: synchronous, active-low reset.
- `req_valid_i` in NREQ: per-requester ready-to-issue.
- `req_alu_op_i` in NREQ*OP_W: packed opcodes; requester k occupies slice [k*OP_W +: OP_W].
- `req_src1_i`, `req_src2_i` in NREQ*DATA_LEN: packed operands.
- `req_wrrf_i` in NREQ: op writes the RRF.
- `req_rrf_tag_i` in NREQ*RRF_W: packed destination RRF tags.
- `req_rob_tag_i` in NREQ*ROB_W: packed ROB tags.
- `stall_i` in 1: writeback slot unavailable; grant nothing this cycle.
- `flush_i` in 1: misprediction kill; discards all in-flight ops.
- `grant_o` out NREQ: one-hot or zero, combinational. The requester frees its entry on the same edge.
- `exe_issue_o` out 1: drives the exe unit's `issue_i`.
- `exe_alu_op_o` out OP_W: drives the exe unit's `alu_op_i`.
- `exe_src1_o`, `exe_src2_o` out DATA_LEN: drive the exe unit's `src1_i` and `src2_i`.
- `exe_wrrf_o` out 1: drives the exe unit's `if_write_rrf_i`.
- `wb_valid_o` out 1: the result on the exe unit's `result_o` this cycle is architecturally live.
- `wb_rrf_tag_o` out RRF_W, `wb_rob_tag_o` out ROB_W: tags for that result.
- `busy_o` out 1: stage A or stage B holds a valid op.

## Operation
Arbiter:
- Requester k is eligible when `req_valid_i[k] & ~stall_i & ~flush_i & reset_i`.
- Round-robin pointer `ptr` (log2 NREQ bits). Priority order is `ptr`, `ptr`+1, …, wrapping modulo NREQ.
- After a grant to k, `ptr` becomes (k+1) mod NREQ. With no grant, `ptr` is unchanged.
- At most one `grant_o` bit is set per cycle.

Stage A (issue register):
- Captures the winner's op, srcs, wrrf, and tags.
- `valid_A` becomes 1 on a grant, otherwise 0.

Stage B (execute register):
- Copies stage A every cycle. Stage B never stalls because ALU latency is fixed.
- `valid_B` <= `valid_A & ~flush_i`.

Outputs:
- `exe_issue_o` = `valid_A & ~flush_i`.
- `exe_alu_op_o`, `exe_src*_o`, `exe_wrrf_o` are driven from stage B registers, so they are stable during the exe unit's busy cycle.
- `wb_valid_o` = `valid_B & ~flush_i`. `wb_*_tag_o` are driven from stage B.
- Downstream ROB/RRF writes must be qualified with `wb_valid_o`, because the exe unit's `busy` cannot be cancelled once set.

Flush:
- `flush_i` in any cycle zeroes `grant_o`.
- `valid_A` and `valid_B` are 0 on the next edge.
- The current `exe_issue_o` and `wb_valid_o` are suppressed combinationally.

Reset (`reset_i`=0 at an edge):
- `ptr`=0, `valid_A`=`valid_B`=0, all data registers 0.
- While `reset_i`=0, `grant_o`=0.
- All outputs read 0 after the reset edge.

## Timing
- Cycle T: `grant_o[k]`=1.
- Cycle T+1: `exe_issue_o`=1, and stage A holds op k.
- Cycle T+2: exe unit `busy`=1, `exe_src*_o` hold op k, `result_o` is valid, and `wb_valid_o`=1 with op k's tags.
- Grant-to-result latency is 2 cycles.
- Back-to-back grants in T and T+1 produce results in T+2 and T+3 with no bubble.
- `stall_i` in cycle T creates exactly one result bubble in T+2.
- Simultaneous `stall_i` and `flush_i`: flush semantics apply; nothing is granted.
- `req_valid_i` that drops without a grant has no effect on state.

## Test plan
- Reset, then `req_valid_i`=4'b0001, op=ADD, src1=5, src2=7, rrf_tag=3, rob_tag=9.
  - `grant_o`=0001 in T; `exe_issue_o`=1 in T+1.
  - In T+2: `exe_src1_o`=5, `exe_src2_o`=7, `result_o`=12, `wb_valid_o`=1, `wb_rrf_tag_o`=3, `wb_rob_tag_o`=9.
- `req_valid_i`=4'b1111 held for 6 cycles from reset.
  - Grants are 0001, 0010, 0100, 1000, 0001, 0010.
  - `wb_valid_o`=1 for 6 consecutive cycles starting 2 cycles after the first grant.
- `req_valid_i`=4'b1010 after a grant to 1 (`ptr`=2) → next grant is 1000, then 0010.
- `stall_i`=1 for one cycle amid continuous requests → `grant_o`=0 that cycle, `ptr` is held, and `wb_valid_o`=0 exactly 2 cycles later.
- Grants in T and T+1, then `flush_i`=1 in T+2.
  - In T+2: `grant_o`=0, `exe_issue_o`=0, `wb_valid_o`=0.
  - In T+3: `wb_valid_o`=0 and `busy_o`=0.
- `reset_i`=0 asserted with ops in both stages → after the edge all outputs are 0 and `ptr`=0. The first post-reset grant goes to the lowest valid index.
